// File: rtl/saikoro_reader_if.sv
// Dice-reader signal bundle: roll control and lamp pattern in,
// accepted value, pulses and histogram readout out.
interface saikoro_reader_if;
  logic       enable;
  logic [6:0] lamp;
  logic [2:0] sel;
  logic [2:0] value;
  logic       valid;
  logic       error;
  logic [7:0] face_cnt;
  logic [9:0] roll_cnt;

  modport master (
    output enable,
    output lamp,
    output sel,
    input  value,
    input  valid,
    input  error,
    input  face_cnt,
    input  roll_cnt
  );

  modport slave (
    input  enable,
    input  lamp,
    input  sel,
    output value,
    output valid,
    output error,
    output face_cnt,
    output roll_cnt
  );
endinterface

// File: rtl/saikoro_reader.sv
// Reads an LED dice once it stops rolling: debounces the lamp
// pattern, decodes the face and keeps a saturating histogram.
module saikoro_reader #(
  parameter int STABLE_CYC = 2
) (
  input  logic       ck,
  input  logic       reset,
  saikoro_reader_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ROLL   = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYC);

  logic [1:0] r_state;
  logic [6:0] r_last_lamp;
  logic [3:0] r_cnt;
  logic [2:0] r_value;
  logic       r_valid;
  logic       r_error;
  logic [7:0] r_face_cnt [6];
  logic [9:0] r_roll_cnt;

  logic [2:0] w_face;
  logic       w_stable;
  logic       w_same;
  logic       w_finish;
  logic       w_accept;
  logic [7:0] w_face_cnt;

  // Face decode of the held pattern; 0 marks an illegal code
  always_comb begin
    w_face = 3'd0;
    unique case (1'b1)
      (r_last_lamp == 7'b0000001): w_face = 3'd1;
      (r_last_lamp == 7'b0000110): w_face = 3'd2;
      (r_last_lamp == 7'b0000111): w_face = 3'd3;
      (r_last_lamp == 7'b0011110): w_face = 3'd4;
      (r_last_lamp == 7'b0011111): w_face = 3'd5;
      (r_last_lamp == 7'b1111110): w_face = 3'd6;
      default: ;
    endcase
  end

  assign w_stable = (r_cnt == STABLE_N);
  assign w_same   = (bus.lamp == r_last_lamp);
  assign w_finish = (r_state == S_SETTLE)
                  && !bus.enable
                  && w_stable;
  assign w_accept = w_finish && (w_face != 3'd0);

  always_ff @(posedge ck) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_last_lamp <= 7'd0;
      r_cnt       <= 4'd0;
      r_value     <= 3'd0;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.enable)
            r_state <= S_ROLL;
        end
        S_ROLL: begin
          if (!bus.enable) begin
            r_state     <= S_SETTLE;
            r_last_lamp <= bus.lamp;
            r_cnt       <= 4'd1;
          end
        end
        S_SETTLE: begin
          if (bus.enable) begin
            r_state <= S_ROLL;
          end else if (w_stable) begin
            // Enough identical samples held: judge without a new compare
            r_state <= S_DONE;
            if (w_face != 3'd0) begin
              r_value <= w_face;
              r_valid <= 1'b1;
            end else begin
              r_error <= 1'b1;
            end
          end else if (!w_same) begin
            r_last_lamp <= bus.lamp;
            r_cnt       <= 4'd1;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_state <= bus.enable ? S_ROLL : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      for (int i = 0; i < 6; i++)
        r_face_cnt[i] <= 8'd0;
      r_roll_cnt <= 10'd0;
    end else if (w_accept) begin
      for (int i = 0; i < 6; i++) begin
        if (w_face == 3'(i + 1)
            && r_face_cnt[i] != 8'hFF)
          r_face_cnt[i] <= r_face_cnt[i] + 8'd1;
      end
      if (r_roll_cnt != 10'h3FF)
        r_roll_cnt <= r_roll_cnt + 10'd1;
    end
  end

  always_comb begin
    w_face_cnt = 8'd0;
    case (bus.sel)
      3'd1: w_face_cnt = r_face_cnt[0];
      3'd2: w_face_cnt = r_face_cnt[1];
      3'd3: w_face_cnt = r_face_cnt[2];
      3'd4: w_face_cnt = r_face_cnt[3];
      3'd5: w_face_cnt = r_face_cnt[4];
      3'd6: w_face_cnt = r_face_cnt[5];
      default: ;
    endcase
  end

  assign bus.value    = r_value;
  assign bus.valid    = r_valid;
  assign bus.error    = r_error;
  assign bus.face_cnt = w_face_cnt;
  assign bus.roll_cnt = r_roll_cnt;

endmodule

// File: tb/tb_saikoro_reader.sv
// Directed bench for the dice reader: accept, debounce, abort,
// reject, saturation and reset during settle.
module tb_saikoro_reader;

  logic ck;
  logic reset;
  int   checks;
  int   errors;

  saikoro_reader_if bus ();

  saikoro_reader #(.STABLE_CYC(2)) dut (
    .ck    (ck),
    .reset (reset),
    .bus   (bus)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.lamp = 7'd0;
    bus.sel = 3'd6;
    step();
    step();
    reset = 1'b0;
    step();
    checks++;
    if (bus.value !== 3'd0) begin
      errors++;
      $display("FAIL rst_value got %0d exp 0", bus.value);
    end
    checks++;
    if (bus.valid !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulses got v%0b e%0b exp 0 0",
               bus.valid, bus.error);
    end
    checks++;
    if (bus.roll_cnt !== 10'd0 || bus.face_cnt !== 8'd0) begin
      errors++;
      $display("FAIL rst_counts got r%0d f%0d exp 0 0",
               bus.roll_cnt, bus.face_cnt);
    end
  endtask

  task automatic test_accept();
    bus.enable = 1'b1;
    bus.lamp = 7'b0101010;
    for (int i = 0; i < 5; i++) step();
    bus.enable = 1'b0;
    bus.lamp = 7'b1111110;
    step();
    step();
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL acc_early got %0b exp 0", bus.valid);
    end
    step();
    checks++;
    if (bus.valid !== 1'b1 || bus.value !== 3'd6) begin
      errors++;
      $display("FAIL acc_pulse got v%0b val%0d exp v1 val6",
               bus.valid, bus.value);
    end
    checks++;
    if (bus.roll_cnt !== 10'd1) begin
      errors++;
      $display("FAIL acc_roll got %0d exp 1", bus.roll_cnt);
    end
    step();
    checks++;
    if (bus.valid !== 1'b0 || bus.face_cnt !== 8'd1) begin
      errors++;
      $display("FAIL acc_after got v%0b f%0d exp v0 f1",
               bus.valid, bus.face_cnt);
    end
  endtask

  task automatic test_debounce();
    int nvalid;
    nvalid = 0;
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.lamp = (i % 2 == 0) ? 7'b0000001 : 7'b0000110;
      step();
      if (bus.valid === 1'b1) nvalid++;
    end
    step();
    if (bus.valid === 1'b1) nvalid++;
    checks++;
    if (nvalid != 0) begin
      errors++;
      $display("FAIL deb_early got %0d exp 0", nvalid);
    end
    step();
    checks++;
    if (bus.valid !== 1'b1 || bus.value !== 3'd2) begin
      errors++;
      $display("FAIL deb_pulse got v%0b val%0d exp v1 val2",
               bus.valid, bus.value);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.valid === 1'b1) nvalid++;
    end
    checks++;
    if (nvalid != 0 || bus.roll_cnt !== 10'd2) begin
      errors++;
      $display("FAIL deb_single got extra%0d r%0d exp 0 2",
               nvalid, bus.roll_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    bus.lamp = 7'b0011111;
    step();
    step();
    step();
    checks++;
    if (bus.valid !== 1'b1 || bus.value !== 3'd5) begin
      errors++;
      $display("FAIL b2b_first got v%0b val%0d exp v1 val5",
               bus.valid, bus.value);
    end
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    bus.lamp = 7'b0011110;
    step();
    step();
    checks++;
    if (bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap got %0b exp 0", bus.valid);
    end
    step();
    checks++;
    if (bus.valid !== 1'b1 || bus.value !== 3'd4
        || bus.roll_cnt !== 10'd4) begin
      errors++;
      $display("FAIL b2b_second got v%0b val%0d r%0d exp 1 4 4",
               bus.valid, bus.value, bus.roll_cnt);
    end
    step();
  endtask

  task automatic test_abort();
    int npulse;
    npulse = 0;
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    bus.lamp = 7'b0000001;
    step();
    bus.enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.valid === 1'b1 || bus.error === 1'b1) npulse++;
    end
    checks++;
    if (npulse != 0) begin
      errors++;
      $display("FAIL abort_pulse got %0d exp 0", npulse);
    end
    checks++;
    if (bus.roll_cnt !== 10'd4 || bus.value !== 3'd4) begin
      errors++;
      $display("FAIL abort_state got r%0d val%0d exp 4 4",
               bus.roll_cnt, bus.value);
    end
  endtask

  task automatic test_reject();
    bus.enable = 1'b0;
    bus.lamp = 7'b1000000;
    step();
    step();
    step();
    checks++;
    if (bus.error !== 1'b1 || bus.valid !== 1'b0) begin
      errors++;
      $display("FAIL rej_pulse got e%0b v%0b exp e1 v0",
               bus.error, bus.valid);
    end
    checks++;
    if (bus.value !== 3'd4 || bus.roll_cnt !== 10'd4) begin
      errors++;
      $display("FAIL rej_hold got val%0d r%0d exp 4 4",
               bus.value, bus.roll_cnt);
    end
    step();
    checks++;
    if (bus.error !== 1'b0) begin
      errors++;
      $display("FAIL rej_once got %0b exp 0", bus.error);
    end
  endtask

  task automatic test_saturate();
    int nvalid;
    nvalid = 0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.sel = 3'd3;
    for (int r = 0; r < 260; r++) begin
      bus.enable = 1'b1;
      step();
      bus.enable = 1'b0;
      bus.lamp = 7'b0000111;
      step();
      step();
      step();
      if (bus.valid === 1'b1 && bus.value === 3'd3) nvalid++;
      step();
    end
    checks++;
    if (nvalid != 260) begin
      errors++;
      $display("FAIL sat_pulses got %0d exp 260", nvalid);
    end
    checks++;
    if (bus.face_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_face got %0d exp 255", bus.face_cnt);
    end
    checks++;
    if (bus.roll_cnt !== 10'd260) begin
      errors++;
      $display("FAIL sat_roll got %0d exp 260", bus.roll_cnt);
    end
    bus.sel = 3'd0;
    #1;
    checks++;
    if (bus.face_cnt !== 8'd0) begin
      errors++;
      $display("FAIL sel0 got %0d exp 0", bus.face_cnt);
    end
    bus.sel = 3'd7;
    #1;
    checks++;
    if (bus.face_cnt !== 8'd0) begin
      errors++;
      $display("FAIL sel7 got %0d exp 0", bus.face_cnt);
    end
    bus.sel = 3'd1;
    #1;
    checks++;
    if (bus.face_cnt !== 8'd0) begin
      errors++;
      $display("FAIL sel1 got %0d exp 0", bus.face_cnt);
    end
  endtask

  task automatic test_reset_settle();
    int npulse;
    npulse = 0;
    bus.sel = 3'd3;
    bus.enable = 1'b1;
    step();
    bus.enable = 1'b0;
    bus.lamp = 7'b0000001;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    if (bus.valid === 1'b1) npulse++;
    checks++;
    if (bus.value !== 3'd0 || bus.roll_cnt !== 10'd0
        || bus.face_cnt !== 8'd0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL rst_settle got val%0d r%0d f%0d e%0b exp 0",
               bus.value, bus.roll_cnt, bus.face_cnt, bus.error);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus.valid === 1'b1) npulse++;
    end
    checks++;
    if (npulse != 0) begin
      errors++;
      $display("FAIL rst_settle_pulse got %0d exp 0", npulse);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_accept();
    test_debounce();
    test_back_to_back();
    test_abort();
    test_reject();
    test_saturate();
    test_reset_settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
